// File: rtl/id_ex_operand_reg.sv
// rtl/id_ex_operand_reg.sv - ID/EX pipeline register with MEM/WB operand forwarding
module id_ex_operand_reg #(
  parameter int WIDTH   = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic [WIDTH-1:0]   id_pc,
  input  logic [RADDR_W-1:0] id_rs_addr,
  input  logic [RADDR_W-1:0] id_rt_addr,
  input  logic [WIDTH-1:0]   id_rs_data,
  input  logic [WIDTH-1:0]   id_rt_data,
  input  logic [WIDTH-1:0]   id_imm,
  input  logic [4:0]         id_shamt,
  input  logic [2:0]         id_alu_op,
  input  logic               id_a_sel,
  input  logic               id_b_sel,
  input  logic [RADDR_W-1:0] id_wr_addr,
  input  logic               id_reg_write,
  input  logic               mem_reg_write,
  input  logic [RADDR_W-1:0] mem_wr_addr,
  input  logic [WIDTH-1:0]   mem_fwd_data,
  input  logic               wb_reg_write,
  input  logic [RADDR_W-1:0] wb_wr_addr,
  input  logic [WIDTH-1:0]   wb_wr_data,
  output logic [WIDTH-1:0]   ex_a,
  output logic [WIDTH-1:0]   ex_b,
  output logic [2:0]         ex_alu_op,
  output logic [WIDTH-1:0]   ex_rt_fwd,
  output logic [WIDTH-1:0]   ex_pc,
  output logic [RADDR_W-1:0] ex_wr_addr,
  output logic               ex_reg_write,
  output logic               ex_valid
);

  // All-zero contents double as the bubble: alu_op 0, no write, not valid.
  typedef struct packed {
    logic [WIDTH-1:0]   pc;
    logic [RADDR_W-1:0] rs_addr;
    logic [RADDR_W-1:0] rt_addr;
    logic [WIDTH-1:0]   rs_data;
    logic [WIDTH-1:0]   rt_data;
    logic [WIDTH-1:0]   imm;
    logic [4:0]         shamt;
    logic [2:0]         alu_op;
    logic               a_sel;
    logic               b_sel;
    logic [RADDR_W-1:0] wr_addr;
    logic               reg_write;
    logic               valid;
  } stage_t;

  stage_t stage_q, stage_d;

  logic wb_hits_rs, wb_hits_rt;
  logic [WIDTH-1:0] fwd_rs, fwd_rt;

  // A WB write to a held source register would otherwise be lost once the
  // producer retires, so a stalled stage absorbs it into its latched data.
  assign wb_hits_rs = wb_reg_write && (wb_wr_addr != '0) && (wb_wr_addr == stage_q.rs_addr);
  assign wb_hits_rt = wb_reg_write && (wb_wr_addr != '0) && (wb_wr_addr == stage_q.rt_addr);

  // Next-state selection: flush beats stall beats load.
  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d = '0;
    end else if (stall) begin
      if (wb_hits_rs) stage_d.rs_data = wb_wr_data;
      if (wb_hits_rt) stage_d.rt_data = wb_wr_data;
    end else begin
      stage_d.pc        = id_pc;
      stage_d.rs_addr   = id_rs_addr;
      stage_d.rt_addr   = id_rt_addr;
      stage_d.rs_data   = id_rs_data;
      stage_d.rt_data   = id_rt_data;
      stage_d.imm       = id_imm;
      stage_d.shamt     = id_shamt;
      stage_d.alu_op    = id_alu_op;
      stage_d.a_sel     = id_a_sel;
      stage_d.b_sel     = id_b_sel;
      stage_d.wr_addr   = id_wr_addr;
      stage_d.reg_write = id_reg_write;
      stage_d.valid     = 1'b1;
    end
  end

  // Pipeline register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) stage_q <= '0;
    else       stage_q <= stage_d;
  end

  // Forwarding muxes: $0 never forwarded, MEM is younger so it wins over WB.
  always_comb begin
    fwd_rs = stage_q.rs_data;
    fwd_rt = stage_q.rt_data;
    if (stage_q.rs_addr != '0) begin
      if (mem_reg_write && (mem_wr_addr == stage_q.rs_addr))     fwd_rs = mem_fwd_data;
      else if (wb_reg_write && (wb_wr_addr == stage_q.rs_addr))  fwd_rs = wb_wr_data;
    end
    if (stage_q.rt_addr != '0) begin
      if (mem_reg_write && (mem_wr_addr == stage_q.rt_addr))     fwd_rt = mem_fwd_data;
      else if (wb_reg_write && (wb_wr_addr == stage_q.rt_addr))  fwd_rt = wb_wr_data;
    end
  end

  assign ex_a         = stage_q.a_sel ? {{(WIDTH-5){1'b0}}, stage_q.shamt} : fwd_rs;
  assign ex_b         = stage_q.b_sel ? stage_q.imm : fwd_rt;
  assign ex_rt_fwd    = fwd_rt;
  assign ex_alu_op    = stage_q.alu_op;
  assign ex_pc        = stage_q.pc;
  assign ex_wr_addr   = stage_q.wr_addr;
  assign ex_reg_write = stage_q.reg_write;
  assign ex_valid     = stage_q.valid;

endmodule

// File: tb/tb_id_ex_operand_reg.sv
// tb/tb_id_ex_operand_reg.sv - directed bench for id_ex_operand_reg
module tb_id_ex_operand_reg;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic [31:0] id_pc, id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs_addr, id_rt_addr, id_shamt, id_wr_addr;
  logic [2:0]  id_alu_op;
  logic        id_a_sel, id_b_sel, id_reg_write;
  logic        mem_reg_write, wb_reg_write;
  logic [4:0]  mem_wr_addr, wb_wr_addr;
  logic [31:0] mem_fwd_data, wb_wr_data;
  logic [31:0] ex_a, ex_b, ex_rt_fwd, ex_pc;
  logic [2:0]  ex_alu_op;
  logic [4:0]  ex_wr_addr;
  logic        ex_reg_write, ex_valid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_operand_reg #(.WIDTH(32), .RADDR_W(5)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .id_pc(id_pc), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_shamt(id_shamt), .id_alu_op(id_alu_op), .id_a_sel(id_a_sel),
    .id_b_sel(id_b_sel), .id_wr_addr(id_wr_addr), .id_reg_write(id_reg_write),
    .mem_reg_write(mem_reg_write), .mem_wr_addr(mem_wr_addr), .mem_fwd_data(mem_fwd_data),
    .wb_reg_write(wb_reg_write), .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data),
    .ex_a(ex_a), .ex_b(ex_b), .ex_alu_op(ex_alu_op), .ex_rt_fwd(ex_rt_fwd),
    .ex_pc(ex_pc), .ex_wr_addr(ex_wr_addr), .ex_reg_write(ex_reg_write), .ex_valid(ex_valid)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                        input logic [4:0] sh, input logic [2:0] op, input logic asel,
                        input logic bsel, input logic [4:0] wa, input logic we);
    id_pc = pc; id_rs_addr = rs; id_rt_addr = rt; id_rs_data = rsd; id_rt_data = rtd;
    id_imm = imm; id_shamt = sh; id_alu_op = op; id_a_sel = asel; id_b_sel = bsel;
    id_wr_addr = wa; id_reg_write = we;
  endtask

  task automatic set_fwd(input logic mwe, input logic [4:0] ma, input logic [31:0] md,
                         input logic wwe, input logic [4:0] wa, input logic [31:0] wd);
    mem_reg_write = mwe; mem_wr_addr = ma; mem_fwd_data = md;
    wb_reg_write = wwe; wb_wr_addr = wa; wb_wr_data = wd;
  endtask

  initial begin
    stall = 1'b0; flush = 1'b0; reset = 1'b1;
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    set_id(32'hDEAD_BEEF, 5'd3, 5'd4, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333,
           5'd7, 3'b101, 1'b1, 1'b1, 5'd9, 1'b1);
    #2;

    // 1. reset with nonzero ID fields
    step();
    check("rst_a", ex_a, 32'h0);
    check("rst_b", ex_b, 32'h0);
    check("rst_op", {29'b0, ex_alu_op}, 32'h0);
    check("rst_rtf", ex_rt_fwd, 32'h0);
    check("rst_pc", ex_pc, 32'h0);
    check("rst_wa", {27'b0, ex_wr_addr}, 32'h0);
    check("rst_we", {31'b0, ex_reg_write}, 32'h0);
    check("rst_valid", {31'b0, ex_valid}, 32'h0);
    reset = 1'b0;

    // 2. plain load
    set_id(32'h0000_0100, 5'd1, 5'd2, 32'd5, 32'd7, 32'h0000_1234, 5'd0, 3'b010, 1'b0, 1'b0, 5'd3, 1'b1);
    step();
    check("ld_a", ex_a, 32'd5);
    check("ld_b", ex_b, 32'd7);
    check("ld_valid", {31'b0, ex_valid}, 32'h1);
    check("ld_pc", ex_pc, 32'h0000_0100);
    check("ld_op", {29'b0, ex_alu_op}, 32'h2);
    check("ld_wa", {27'b0, ex_wr_addr}, 32'd3);
    check("ld_we", {31'b0, ex_reg_write}, 32'h1);

    // immediate B keeps rt on the store-data path
    id_b_sel = 1'b1;
    step();
    check("imm_b", ex_b, 32'h0000_1234);
    check("imm_rtf", ex_rt_fwd, 32'd7);

    // 3. MEM beats WB, then WB alone
    set_id(32'h0000_0104, 5'd8, 5'd2, 32'h55, 32'd7, 32'h0, 5'd0, 3'b001, 1'b0, 1'b0, 5'd10, 1'b1);
    step();
    set_fwd(1'b1, 5'd8, 32'h11, 1'b1, 5'd8, 32'h22);
    #1;
    check("fwd_mem_wins", ex_a, 32'h11);
    mem_reg_write = 1'b0;
    #1;
    check("fwd_wb", ex_a, 32'h22);
    wb_reg_write = 1'b0;
    #1;
    check("fwd_none", ex_a, 32'h55);
    set_fwd(1'b1, 5'd2, 32'h66, 1'b0, 5'd0, 32'h0);
    #1;
    check("fwd_rt_mem", ex_b, 32'h66);
    check("fwd_rt_store", ex_rt_fwd, 32'h66);
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // 4. $0 is never forwarded
    set_id(32'h0000_0108, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 3'b000, 1'b0, 1'b0, 5'd1, 1'b1);
    step();
    set_fwd(1'b1, 5'd0, 32'hFF, 1'b1, 5'd0, 32'hEE);
    #1;
    check("zero_a", ex_a, 32'h0);
    check("zero_b", ex_b, 32'h0);
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // 5. stall with WB refresh of held rs/rt
    set_id(32'h0000_0200, 5'd9, 5'd9, 32'h1, 32'h2, 32'h0, 5'd0, 3'b011, 1'b0, 1'b0, 5'd12, 1'b1);
    step();
    check("stl_load_a", ex_a, 32'h1);
    stall = 1'b1;
    set_id(32'h0000_0300, 5'd4, 5'd5, 32'hAA, 32'hBB, 32'h0, 5'd0, 3'b100, 1'b0, 1'b0, 5'd13, 1'b1);
    step();
    check("stl_c1_a", ex_a, 32'h1);
    check("stl_c1_pc", ex_pc, 32'h0000_0200);
    set_fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h33);
    step();
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    check("stl_c2_a", ex_a, 32'h33);
    check("stl_c2_rt", ex_rt_fwd, 32'h33);
    step();
    check("stl_c3_a", ex_a, 32'h33);
    check("stl_c3_op", {29'b0, ex_alu_op}, 32'h3);
    stall = 1'b0;
    #1;
    check("stl_rel_a", ex_a, 32'h33);
    step();
    check("post_a", ex_a, 32'hAA);
    check("post_pc", ex_pc, 32'h0000_0300);

    // 6. flush overrides stall
    flush = 1'b1; stall = 1'b1;
    step();
    check("fl_valid", {31'b0, ex_valid}, 32'h0);
    check("fl_we", {31'b0, ex_reg_write}, 32'h0);
    check("fl_wa", {27'b0, ex_wr_addr}, 32'h0);
    check("fl_a", ex_a, 32'h0);
    flush = 1'b0; stall = 1'b0;

    // sll: A from shamt, B from rt
    set_id(32'h0000_0400, 5'd6, 5'd7, 32'h99, 32'h1, 32'h0, 5'd4, 3'b110, 1'b1, 1'b0, 5'd8, 1'b1);
    step();
    check("sll_a", ex_a, 32'd4);
    check("sll_b", ex_b, 32'd1);
    check("sll_valid", {31'b0, ex_valid}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
